// File: rtl/ram_1r1w_arbiter.sv
// Shares one ram_1r1w_sync between two clients: round-robin arbitration per RAM port,
// tagged latency-1 read responses, and an optional zero-fill of the RAM after reset.
module ram_1r1w_arbiter #(
    parameter int width_p      = 8,
    parameter int depth_p      = 512,
    parameter bit init_clear_p = 1'b1,
    localparam int aw          = $clog2(depth_p)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,

    input  logic [1:0]           wr_valid_i,
    output logic [1:0]           wr_ready_o,
    input  logic [2*aw-1:0]      wr_addr_i,
    input  logic [2*width_p-1:0] wr_data_i,

    input  logic [1:0]           rd_valid_i,
    output logic [1:0]           rd_ready_o,
    input  logic [2*aw-1:0]      rd_addr_i,

    output logic                 rsp_valid_o,
    output logic                 rsp_id_o,
    output logic [width_p-1:0]   rsp_data_o,

    output logic                 ram_wr_valid_o,
    output logic [aw-1:0]        ram_wr_addr_o,
    output logic [width_p-1:0]   ram_wr_data_o,
    output logic                 ram_rd_valid_o,
    output logic [aw-1:0]        ram_rd_addr_o,
    input  logic [width_p-1:0]   ram_rd_data_i,

    output logic                 init_done_o
);

    localparam logic [0:0]    st_clear  = 1'b0;
    localparam logic [0:0]    st_run    = 1'b1;
    localparam logic [aw-1:0] last_addr = aw'(depth_p - 1);

    logic [0:0]    state_q, state_d;
    logic [aw-1:0] clr_cnt_q;
    logic          init_done_q;
    logic          wr_ptr_q, rd_ptr_q;
    logic          rsp_valid_q, rsp_id_q;
    logic [1:0]    wr_grant, rd_grant;
    logic          grant_en, clearing;

    // Reset is synchronous, so the reset cycle itself must be masked combinationally.
    assign grant_en = reset_i & init_done_q;
    assign clearing = reset_i & (state_q == st_clear);

    // On contention the client that did not win last time is picked.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
        logic [1:0] pick;
        pick = req;
        if (req == 2'b11) begin
            pick = last ? 2'b01 : 2'b10;
        end
        return pick;
    endfunction

    assign wr_grant   = grant_en ? rr_pick(wr_valid_i, wr_ptr_q) : 2'b00;
    assign rd_grant   = grant_en ? rr_pick(rd_valid_i, rd_ptr_q) : 2'b00;
    assign wr_ready_o = wr_grant;
    assign rd_ready_o = rd_grant;

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        ram_wr_valid_o = clearing | (|wr_grant);
        ram_wr_addr_o  = wr_grant[1] ? wr_addr_i[aw +: aw] : wr_addr_i[0 +: aw];
        ram_wr_data_o  = wr_grant[1] ? wr_data_i[width_p +: width_p] : wr_data_i[0 +: width_p];
        if (clearing) begin
            ram_wr_addr_o = clr_cnt_q;
            ram_wr_data_o = '0;
        end
    end

    assign ram_rd_valid_o = |rd_grant;
    assign ram_rd_addr_o  = rd_grant[1] ? rd_addr_i[aw +: aw] : rd_addr_i[0 +: aw];

    always_comb begin
        state_d = state_q;
        if ((state_q == st_clear) && (clr_cnt_q == last_addr)) begin
            state_d = st_run;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q     <= init_clear_p ? st_clear : st_run;
            clr_cnt_q   <= '0;
            init_done_q <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == st_clear) begin
                clr_cnt_q <= clr_cnt_q + aw'(1);
            end
            init_done_q <= (state_d == st_run);
            if (|wr_grant) begin
                wr_ptr_q <= wr_grant[1];
            end
            if (|rd_grant) begin
                rd_ptr_q <= rd_grant[1];
            end
            rsp_valid_q <= |rd_grant;
            rsp_id_q    <= rd_grant[1];
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_data_o  = ram_rd_data_i;
    assign init_done_o = init_done_q;

endmodule

// File: tb/tb_ram_1r1w_arbiter.sv
// Directed bench for ram_1r1w_arbiter (depth 8) with a behavioural synchronous 1R1W RAM.
module tb_ram_1r1w_arbiter;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int AW = 3;

    logic            clk_i = 1'b0;
    logic            reset_i;
    logic [1:0]      wr_valid_i, wr_ready_o;
    logic [2*AW-1:0] wr_addr_i;
    logic [2*W-1:0]  wr_data_i;
    logic [1:0]      rd_valid_i, rd_ready_o;
    logic [2*AW-1:0] rd_addr_i;
    logic            rsp_valid_o, rsp_id_o;
    logic [W-1:0]    rsp_data_o;
    logic            ram_wr_valid_o, ram_rd_valid_o;
    logic [AW-1:0]   ram_wr_addr_o, ram_rd_addr_o;
    logic [W-1:0]    ram_wr_data_o, ram_rd_data_i;
    logic            init_done_o;

    int n_cmp = 0;
    int n_err = 0;

    ram_1r1w_arbiter #(.width_p(W), .depth_p(D), .init_clear_p(1'b1)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .rd_valid_i(rd_valid_i), .rd_ready_o(rd_ready_o), .rd_addr_i(rd_addr_i),
        .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o), .rsp_data_o(rsp_data_o),
        .ram_wr_valid_o(ram_wr_valid_o), .ram_wr_addr_o(ram_wr_addr_o), .ram_wr_data_o(ram_wr_data_o),
        .ram_rd_valid_o(ram_rd_valid_o), .ram_rd_addr_o(ram_rd_addr_o), .ram_rd_data_i(ram_rd_data_i),
        .init_done_o(init_done_o)
    );

    always #5 clk_i = ~clk_i;

    // Synchronous RAM: a same-cycle read of a written address returns the old word.
    logic [W-1:0] mem [D];
    always @(posedge clk_i) begin
        if (ram_wr_valid_o) mem[ram_wr_addr_o] <= ram_wr_data_o;
        if (ram_rd_valid_o) ram_rd_data_i <= mem[ram_rd_addr_o];
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        reset_i = 1'b0; wr_valid_i = 2'b11; rd_valid_i = 2'b11;
        wr_addr_i = '0; wr_data_i = '0; rd_addr_i = '0;
        tick; tick;
        n_cmp++; if (wr_ready_o !== 2'b00) begin n_err++; $display("FAIL reset_wr_ready: got %b expected 00", wr_ready_o); end
        n_cmp++; if (rd_ready_o !== 2'b00) begin n_err++; $display("FAIL reset_rd_ready: got %b expected 00", rd_ready_o); end
        n_cmp++; if (ram_wr_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_ram_wr_valid: got %b expected 0", ram_wr_valid_o); end
        n_cmp++; if (ram_rd_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_ram_rd_valid: got %b expected 0", ram_rd_valid_o); end
        n_cmp++; if (rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid_o); end
        n_cmp++; if (rsp_id_o !== 1'b0) begin n_err++; $display("FAIL reset_rsp_id: got %b expected 0", rsp_id_o); end
        n_cmp++; if (init_done_o !== 1'b0) begin n_err++; $display("FAIL reset_init_done: got %b expected 0", init_done_o); end
    endtask

    task automatic test_clear;
        reset_i = 1'b1;
        #1;
        for (int i = 0; i < D; i++) begin
            n_cmp++; if (ram_wr_valid_o !== 1'b1 || ram_wr_addr_o !== 3'(i) || ram_wr_data_o !== 8'h00) begin
                n_err++; $display("FAIL clear_write[%0d]: got v=%b a=%0d d=%h expected v=1 a=%0d d=00", i, ram_wr_valid_o, ram_wr_addr_o, ram_wr_data_o, i);
            end
            n_cmp++; if (wr_ready_o !== 2'b00 || rd_ready_o !== 2'b00 || ram_rd_valid_o !== 1'b0 || init_done_o !== 1'b0) begin
                n_err++; $display("FAIL clear_quiet[%0d]: got wr=%b rd=%b rv=%b done=%b expected 00 00 0 0", i, wr_ready_o, rd_ready_o, ram_rd_valid_o, init_done_o);
            end
            tick;
        end
        n_cmp++; if (init_done_o !== 1'b1) begin n_err++; $display("FAIL clear_init_done: got %b expected 1", init_done_o); end
        n_cmp++; if (wr_ready_o !== 2'b10 || rd_ready_o !== 2'b10) begin
            n_err++; $display("FAIL clear_first_grant: got wr=%b rd=%b expected 10 10", wr_ready_o, rd_ready_o);
        end
        wr_valid_i = 2'b00; rd_valid_i = 2'b00;
        #1;
        n_cmp++; if (ram_wr_valid_o !== 1'b0) begin n_err++; $display("FAIL run_idle_wr: got %b expected 0", ram_wr_valid_o); end
        rd_valid_i = 2'b01;
        for (int i = 0; i < D; i++) begin
            rd_addr_i = 6'(i);
            tick;
            n_cmp++; if (rsp_valid_o !== 1'b1 || rsp_id_o !== 1'b0 || rsp_data_o !== 8'h00) begin
                n_err++; $display("FAIL clear_readback[%0d]: got v=%b id=%b d=%h expected v=1 id=0 d=00", i, rsp_valid_o, rsp_id_o, rsp_data_o);
            end
        end
        rd_valid_i = 2'b00;
        tick;
        n_cmp++; if (rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL clear_rsp_end: got %b expected 0", rsp_valid_o); end
    endtask

    task automatic test_write_contention;
        logic [1:0] exp_g [4];
        exp_g = '{2'b10, 2'b01, 2'b10, 2'b01};
        wr_valid_i = 2'b11; wr_addr_i = {3'd5, 3'd3}; wr_data_i = {8'h55, 8'hAA};
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (wr_ready_o !== exp_g[i]) begin n_err++; $display("FAIL contention_grant[%0d]: got %b expected %b", i, wr_ready_o, exp_g[i]); end
            n_cmp++; if (ram_wr_addr_o !== (exp_g[i][1] ? 3'd5 : 3'd3) || ram_wr_data_o !== (exp_g[i][1] ? 8'h55 : 8'hAA)) begin
                n_err++; $display("FAIL contention_mux[%0d]: got a=%0d d=%h grant %b", i, ram_wr_addr_o, ram_wr_data_o, exp_g[i]);
            end
            tick;
        end
        wr_valid_i = 2'b00;
        rd_valid_i = 2'b01; rd_addr_i = {3'd0, 3'd3};
        tick;
        rd_valid_i = 2'b10; rd_addr_i = {3'd5, 3'd0};
        n_cmp++; if (rsp_valid_o !== 1'b1 || rsp_id_o !== 1'b0 || rsp_data_o !== 8'hAA) begin
            n_err++; $display("FAIL contention_read0: got v=%b id=%b d=%h expected v=1 id=0 d=aa", rsp_valid_o, rsp_id_o, rsp_data_o);
        end
        tick;
        rd_valid_i = 2'b00;
        n_cmp++; if (rsp_valid_o !== 1'b1 || rsp_id_o !== 1'b1 || rsp_data_o !== 8'h55) begin
            n_err++; $display("FAIL contention_read1: got v=%b id=%b d=%h expected v=1 id=1 d=55", rsp_valid_o, rsp_id_o, rsp_data_o);
        end
        tick;
    endtask

    task automatic test_pointer_hold;
        wr_valid_i = 2'b10; wr_addr_i = {3'd6, 3'd0}; wr_data_i = {8'h66, 8'h00};
        #1;
        n_cmp++; if (wr_ready_o !== 2'b10) begin n_err++; $display("FAIL hold_single: got %b expected 10", wr_ready_o); end
        tick;
        wr_valid_i = 2'b00;
        tick; tick; tick;
        wr_valid_i = 2'b11; wr_addr_i = {3'd6, 3'd6}; wr_data_i = {8'h66, 8'h60};
        #1;
        n_cmp++; if (wr_ready_o !== 2'b01) begin n_err++; $display("FAIL hold_after_idle: got %b expected 01", wr_ready_o); end
        tick;
        wr_valid_i = 2'b00;
        rd_valid_i = 2'b01; rd_addr_i = {3'd0, 3'd6};
        tick;
        rd_valid_i = 2'b00;
        n_cmp++; if (rsp_valid_o !== 1'b1 || rsp_id_o !== 1'b0 || rsp_data_o !== 8'h60) begin
            n_err++; $display("FAIL hold_readback: got v=%b id=%b d=%h expected v=1 id=0 d=60", rsp_valid_o, rsp_id_o, rsp_data_o);
        end
        tick;
    endtask

    task automatic test_read_pipeline;
        logic [7:0] d [3];
        d = '{8'h10, 8'h21, 8'h32};
        wr_valid_i = 2'b01;
        for (int i = 0; i < 3; i++) begin
            wr_addr_i = 6'(i); wr_data_i = {8'h00, d[i]};
            tick;
        end
        wr_valid_i = 2'b00;
        rd_valid_i = 2'b10;
        for (int i = 0; i < 3; i++) begin
            rd_addr_i = {3'(i), 3'd0};
            #1;
            n_cmp++; if (rd_ready_o !== 2'b10 || ram_rd_addr_o !== 3'(i)) begin
                n_err++; $display("FAIL pipe_grant[%0d]: got rdy=%b a=%0d expected rdy=10 a=%0d", i, rd_ready_o, ram_rd_addr_o, i);
            end
            if (i == 0) begin
                n_cmp++; if (rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL pipe_latency: got %b expected 0", rsp_valid_o); end
            end
            tick;
            n_cmp++; if (rsp_valid_o !== 1'b1 || rsp_id_o !== 1'b1 || rsp_data_o !== d[i]) begin
                n_err++; $display("FAIL pipe_rsp[%0d]: got v=%b id=%b d=%h expected v=1 id=1 d=%h", i, rsp_valid_o, rsp_id_o, rsp_data_o, d[i]);
            end
        end
        rd_valid_i = 2'b00;
        tick;
        n_cmp++; if (rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL pipe_end: got %b expected 0", rsp_valid_o); end
    endtask

    task automatic test_hazard;
        wr_valid_i = 2'b01; wr_addr_i = 6'd4; wr_data_i = {8'h00, 8'h11};
        tick;
        wr_data_i = {8'h00, 8'h22};
        rd_valid_i = 2'b10; rd_addr_i = {3'd4, 3'd0};
        tick;
        wr_valid_i = 2'b00;
        n_cmp++; if (rsp_valid_o !== 1'b1 || rsp_id_o !== 1'b1 || rsp_data_o !== 8'h11) begin
            n_err++; $display("FAIL hazard_same_cycle: got v=%b id=%b d=%h expected v=1 id=1 d=11", rsp_valid_o, rsp_id_o, rsp_data_o);
        end
        tick;
        rd_valid_i = 2'b00;
        n_cmp++; if (rsp_valid_o !== 1'b1 || rsp_data_o !== 8'h22) begin
            n_err++; $display("FAIL hazard_next_cycle: got v=%b d=%h expected v=1 d=22", rsp_valid_o, rsp_data_o);
        end
        tick;
    endtask

    task automatic test_fairness;
        logic [1:0] prev;
        prev = 2'b00;
        rd_addr_i = {3'd2, 3'd1};
        for (int i = 0; i < 9; i++) begin
            logic [1:0] exp_g;
            rd_valid_i = (i % 3 == 2) ? 2'b11 : 2'b01;
            exp_g      = (i % 3 == 2) ? 2'b10 : 2'b01;
            #1;
            n_cmp++; if (rd_ready_o !== exp_g) begin n_err++; $display("FAIL fair_grant[%0d]: got %b expected %b", i, rd_ready_o, exp_g); end
            if (i > 0) begin
                n_cmp++; if (rsp_valid_o !== 1'b1 || rsp_id_o !== prev[1] || rsp_data_o !== (prev[1] ? 8'h32 : 8'h21)) begin
                    n_err++; $display("FAIL fair_rsp[%0d]: got v=%b id=%b d=%h expected id=%b", i, rsp_valid_o, rsp_id_o, rsp_data_o, prev[1]);
                end
            end
            prev = exp_g;
            tick;
        end
        rd_valid_i = 2'b00;
        n_cmp++; if (rsp_valid_o !== 1'b1 || rsp_id_o !== 1'b1 || rsp_data_o !== 8'h32) begin
            n_err++; $display("FAIL fair_last_rsp: got v=%b id=%b d=%h expected v=1 id=1 d=32", rsp_valid_o, rsp_id_o, rsp_data_o);
        end
        tick;
    endtask

    task automatic test_reset_mid_clear;
        rd_valid_i = 2'b01; rd_addr_i = {3'd0, 3'd1};
        tick;
        reset_i = 1'b0; rd_valid_i = 2'b11; wr_valid_i = 2'b11; wr_data_i = '0;
        #1;
        n_cmp++; if (rd_ready_o !== 2'b00 || wr_ready_o !== 2'b00) begin
            n_err++; $display("FAIL rst_ready: got rd=%b wr=%b expected 00 00", rd_ready_o, wr_ready_o);
        end
        tick;
        n_cmp++; if (rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_drop_rsp: got %b expected 0", rsp_valid_o); end
        reset_i = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (ram_wr_valid_o !== 1'b1 || ram_wr_addr_o !== 3'(i) || init_done_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
                n_err++; $display("FAIL midclr_pre[%0d]: got v=%b a=%0d done=%b rsp=%b", i, ram_wr_valid_o, ram_wr_addr_o, init_done_o, rsp_valid_o);
            end
            tick;
        end
        n_cmp++; if (ram_wr_addr_o !== 3'd5) begin n_err++; $display("FAIL midclr_at5: got %0d expected 5", ram_wr_addr_o); end
        reset_i = 1'b0;
        #1;
        n_cmp++; if (ram_wr_valid_o !== 1'b0) begin n_err++; $display("FAIL midclr_rst_wr: got %b expected 0", ram_wr_valid_o); end
        tick;
        reset_i = 1'b1;
        #1;
        for (int i = 0; i < D; i++) begin
            n_cmp++; if (ram_wr_valid_o !== 1'b1 || ram_wr_addr_o !== 3'(i) || init_done_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
                n_err++; $display("FAIL midclr_restart[%0d]: got v=%b a=%0d done=%b rsp=%b", i, ram_wr_valid_o, ram_wr_addr_o, init_done_o, rsp_valid_o);
            end
            n_cmp++; if (rd_ready_o !== 2'b00 || wr_ready_o !== 2'b00) begin
                n_err++; $display("FAIL midclr_ready[%0d]: got rd=%b wr=%b expected 00 00", i, rd_ready_o, wr_ready_o);
            end
            tick;
        end
        n_cmp++; if (init_done_o !== 1'b1 || rd_ready_o !== 2'b10) begin
            n_err++; $display("FAIL midclr_done: got done=%b rd=%b expected 1 10", init_done_o, rd_ready_o);
        end
        wr_valid_i = 2'b00; rd_valid_i = 2'b01; rd_addr_i = {3'd0, 3'd4};
        tick;
        rd_valid_i = 2'b00;
        n_cmp++; if (rsp_valid_o !== 1'b1 || rsp_data_o !== 8'h00) begin
            n_err++; $display("FAIL midclr_recleared: got v=%b d=%h expected v=1 d=00", rsp_valid_o, rsp_data_o);
        end
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected normal finish");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_clear;
        test_write_contention;
        test_pointer_hold;
        test_read_pipeline;
        test_hazard;
        test_fairness;
        test_reset_mid_clear;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_1r1w_arbiter.md
Name: ram_1r1w_arbiter

Overview:
Single-clock controller that shares one ram_1r1w_sync instance between two requesters. Each requester has independent read and write request channels. The block arbitrates each RAM port round-robin and returns tagged read responses. After reset it optionally sequences a zero-fill of the whole RAM before granting any request. It sits between client logic and the RAM macro, driving the macro's write and read ports directly.

Parameters:
width_p, 8, data width in bits; must match the RAM.
depth_p, 512, RAM depth in words; aw = $clog2(depth_p).
init_clear_p, 1, 1 = zero-fill the RAM after reset; 0 = skip the fill.

Ports:
clk_i  in  1  single clock for the block and the RAM (tied to both RAM clocks)
reset_i  in  1  synchronous, active-low reset
wr_valid_i  in  2  write request, bit c = client c
wr_ready_o  out  2  write grant, bit c = client c
wr_addr_i  in  2*aw  client c address at [c*aw +: aw]
wr_data_i  in  2*width_p  client c data at [c*width_p +: width_p]
rd_valid_i  in  2  read request, bit c = client c
rd_ready_o  out  2  read grant
rd_addr_i  in  2*aw  client c read address at [c*aw +: aw]
rsp_valid_o  out  1  read response valid (single-cycle pulse)
rsp_id_o  out  1  client that owns the response
rsp_data_o  out  width_p  read data
ram_wr_valid_o  out  1  to RAM wr_valid_i
ram_wr_addr_o  out  aw  to RAM wr_addr_i
ram_wr_data_o  out  width_p  to RAM wr_data_i
ram_rd_valid_o  out  1  to RAM rd_valid_i
ram_rd_addr_o  out  aw  to RAM rd_addr_i
ram_rd_data_i  in  width_p  from RAM rd_data_o
init_done_o  out  1  high once the block accepts requests

Behaviour:
- Reset (reset_i == 0 at a clk_i edge):
  - FSM goes to CLEAR if init_clear_p = 1, else to RUN.
  - Clear counter = 0, both round-robin pointers = 0.
  - rsp_valid_o = 0, rsp_id_o = 0, init_done_o = 0.
  - wr_ready_o, rd_ready_o, ram_wr_valid_o and ram_rd_valid_o are all 0 while in reset.
- FSM CLEAR:
  - Each cycle drives ram_wr_valid_o = 1, ram_wr_addr_o = counter, ram_wr_data_o = 0, then increments the counter.
  - After the write to address depth_p-1 the FSM goes to RUN. The clear takes exactly depth_p cycles.
  - All ready outputs are 0 and ram_rd_valid_o = 0 throughout CLEAR.
- FSM RUN:
  - init_done_o = 1 (registered); it is first high in the cycle after the last clear write.
  - With init_clear_p = 0, it is high in the first cycle after reset is released.
  - RUN is terminal until the next reset.
- Arbitration, identical and independent for the write port and the read port:
  - Grant is combinational from the valid inputs; ready_o[c] = grant[c], and at most one bit is set per port.
  - One requester valid: that requester is granted.
  - Both valid: the requester that is not the pointer is granted. The pointer records the last client granted.
  - The pointer updates only on a grant, so an idle port keeps its pointer.
- Datapath:
  - Write port: ram_wr_valid_o = |wr_ready_o; the mux selects the granted client's address and data.
  - Read port: ram_rd_valid_o = |rd_ready_o; the mux selects the granted client's address.
  - A transfer completes in the cycle that valid and ready are both high.
  - Clients may hold valid across cycles; no combinational path exists from ready to valid inside the block.
- Read response:
  - Latency 1. rsp_valid_o and rsp_id_o are registered copies of ram_rd_valid_o and the granted id.
  - rsp_data_o = ram_rd_data_i, combinational.
  - There is no response backpressure; clients must sink the response in that cycle.
  - Back-to-back grants give back-to-back responses in grant order.
- Read/write hazard: a same-cycle read and write to the same address returns the old data. A read granted the cycle after a write returns the new data.
- Reset mid-operation:
  - Any in-flight response is dropped, so rsp_valid_o = 0 the cycle after reset.
  - A clear in progress restarts at address 0.
  - Write data already committed to the RAM is not restored unless re-cleared.

Test Plan:
- Clear: init_clear_p = 1, depth_p = 8, all requests held high from reset release -> ram_wr_valid_o high for 8 cycles at addresses 0..7 with data 0. Readies stay 0 during the clear. init_done_o rises on cycle 9. Reading every address then returns 0.
- Write contention: both clients write continuously, client 0 to address 3 with data 0xAA, client 1 to address 5 with data 0x55 -> grants alternate 1,0,1,0 (pointer starts at 0). A read of address 3 returns 0xAA with rsp_id_o = 0; a read of address 5 returns 0x55 with rsp_id_o = 1.
- Read pipeline: client 1 alone reads addresses 0,1,2 in consecutive cycles -> rsp_valid_o is high on 3 consecutive cycles, starting one cycle after the first grant. rsp_id_o = 1 and the data matches in order.
- Hazard: write 0x11 to address 4, then in the same cycle write 0x22 to address 4 and read address 4 -> response 0x11. A read on the next cycle -> 0x22.
- Fairness: client 0 read-valid held high, client 1 read-valid pulsed every 3rd cycle -> client 1 is granted on every cycle it is valid. No client waits more than 1 cycle.
- Reset mid-clear: assert reset_i = 0 at clear address 5 for one cycle -> the clear restarts at 0, init_done_o stays 0, and rsp_valid_o stays 0 throughout.
